// File: rtl/sdes_pkg.sv
// Shared definitions for the S-DES block sequencer.
// Stage codes double as the LED pattern on Stage.
package sdes_pkg;

  typedef enum logic [2:0] {
    ST_KEY  = 3'd0,
    ST_MODE = 3'd1,
    ST_IV   = 3'd2,
    ST_LEN  = 3'd3,
    ST_DATA = 3'd4,
    ST_RUN  = 3'd5,
    ST_SHOW = 3'd6
  } stage_t;

  localparam int ENC_BIT = 0;
  localparam int CBC_BIT = 1;

  // Rightmost switch selects "new message" in SHOW.
  function automatic int restart_bit(input int key_w);
    return key_w - 1;
  endfunction

endpackage

// File: rtl/sdes_button_cond.sv
// Push-button conditioner: 2-flop synchroniser, debounce, press pulse.
module sdes_button_cond #(
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

  logic          s1, s2, level;
  logic [CW-1:0] cnt;

  // cnt counts consecutive samples that disagree with the accepted level.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= s2;
        cnt   <= '0;
        press <= s2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sdes_core.sv
// Combinational simplified-DES core, 8-bit block, 10-bit key.
// Bit 1 (index 0 on the ports) is the leftmost bit, as in the textbook tables.
module sdes_core (
  input  logic [0:7] din,
  input  logic [0:9] key,
  input  logic       enc,
  output logic [0:7] dout
);

  localparam logic [0:15][1:0] S0 = '{
    2'd1, 2'd0, 2'd3, 2'd2,
    2'd3, 2'd2, 2'd1, 2'd0,
    2'd0, 2'd2, 2'd1, 2'd3,
    2'd3, 2'd1, 2'd3, 2'd2};
  localparam logic [0:15][1:0] S1 = '{
    2'd0, 2'd1, 2'd2, 2'd3,
    2'd2, 2'd0, 2'd1, 2'd3,
    2'd3, 2'd0, 2'd1, 2'd0,
    2'd2, 2'd1, 2'd0, 2'd3};

  function automatic logic [1:8] p8(input logic [1:10] v);
    return {v[6], v[3], v[7], v[4], v[8], v[5], v[10], v[9]};
  endfunction

  function automatic logic [1:8] fk(
    input logic [1:8] x,
    input logic [1:8] sk
  );
    logic [1:4] r;
    logic [1:4] p;
    logic [1:8] t;
    r = x[5:8];
    t = {r[4], r[1], r[2], r[3], r[2], r[3], r[4], r[1]} ^ sk;
    p = {S0[{t[1], t[4], t[2], t[3]}], S1[{t[5], t[8], t[6], t[7]}]};
    return {x[1:4] ^ {p[2], p[4], p[3], p[1]}, r};
  endfunction

  logic [1:10] k, p10, ls1, ls3;
  logic [1:8]  d, k1, k2, ka, kb, ip, f1, f2;

  assign k   = key;
  assign d   = din;
  assign p10 = {k[3], k[5], k[2], k[7], k[4],
                k[10], k[1], k[9], k[8], k[6]};
  assign ls1 = {p10[2:5], p10[1], p10[7:10], p10[6]};
  assign ls3 = {ls1[3:5], ls1[1:2], ls1[8:10], ls1[6:7]};
  assign k1  = p8(ls1);
  assign k2  = p8(ls3);
  assign ka  = enc ? k1 : k2;
  assign kb  = enc ? k2 : k1;
  assign ip  = {d[2], d[6], d[3], d[1], d[4], d[8], d[5], d[7]};
  assign f1  = fk(ip, ka);
  assign f2  = fk({f1[5:8], f1[1:4]}, kb);
  assign dout = {f2[4], f2[1], f2[3], f2[5],
                 f2[7], f2[2], f2[8], f2[6]};

endmodule

// File: rtl/sdes_block_sequencer.sv
// Multi-block S-DES sequencer: button-driven entry, ECB/CBC run,
// paged result display.
module sdes_block_sequencer
  import sdes_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int KEY_W        = 10,
  parameter int DEPTH        = 4,
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [0:KEY_W-1]         DataIn,
  input  logic                     SelectButton,
  output logic [0:DATA_W-1]        DataOutBlock,
  output logic [2:0]               Stage,
  output logic [$clog2(DEPTH)-1:0] ShowIndex,
  output logic                     Busy,
  output logic                     Done
);

  localparam int LW = $clog2(DEPTH);

  stage_t              state, state_nx;
  logic                press, restart;
  logic [0:KEY_W-1]    key;
  logic                enc, cbc;
  logic [0:DATA_W-1]   iv, chain, dout_q;
  logic [0:DATA_W-1]   core_in, core_out, res_val;
  logic [0:DATA_W-1]   bufm [DEPTH];
  logic [0:DATA_W-1]   res  [DEPTH];
  logic [LW:0]         len;
  logic [LW-1:0]       wp, ri, idx;
  logic                last_wr, last_run, last_show;

  sdes_button_cond #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_btn (
    .clk  (CLK),
    .rst  (RST),
    .btn  (SelectButton),
    .press(press)
  );

  sdes_core u_core (
    .din (core_in),
    .key (key),
    .enc (enc),
    .dout(core_out)
  );

  assign restart   = DataIn[restart_bit(KEY_W)];
  assign last_wr   = ({1'b0, wp} + (LW+1)'(1)) == len;
  assign last_run  = ({1'b0, ri} + (LW+1)'(1)) == len;
  assign last_show = ({1'b0, idx} + (LW+1)'(1)) == len;

  // CBC encrypt whitens the input; CBC decrypt whitens the output.
  assign core_in = (cbc && enc) ? bufm[ri] ^ chain : bufm[ri];
  assign res_val = (cbc && !enc) ? core_out ^ chain : core_out;

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_KEY;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_KEY:  if (press) state_nx = ST_MODE;
      ST_MODE: if (press)
                 state_nx = DataIn[CBC_BIT] ? ST_IV : ST_LEN;
      ST_IV:   if (press) state_nx = ST_LEN;
      ST_LEN:  if (press) state_nx = ST_DATA;
      ST_DATA: if (press && last_wr) state_nx = ST_RUN;
      ST_RUN:  if (last_run) state_nx = ST_SHOW;
      ST_SHOW: if (press && restart) state_nx = ST_KEY;
      default: state_nx = ST_KEY;
    endcase
  end

  always_comb begin
    Stage        = state;
    Busy         = (state == ST_RUN);
    Done         = (state == ST_SHOW);
    ShowIndex    = idx;
    DataOutBlock = Done ? dout_q : '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      key    <= '0;
      enc    <= 1'b0;
      cbc    <= 1'b0;
      iv     <= '0;
      chain  <= '0;
      len    <= '0;
      wp     <= '0;
      ri     <= '0;
      idx    <= '0;
      dout_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        bufm[i] <= '0;
        res[i]  <= '0;
      end
    end else begin
      dout_q <= (state == ST_SHOW) ? res[idx] : '0;
      case (state)
        ST_KEY: if (press) key <= DataIn;
        ST_MODE: if (press) begin
          enc <= DataIn[ENC_BIT];
          cbc <= DataIn[CBC_BIT];
        end
        ST_IV: if (press) iv <= DataIn[0:DATA_W-1];
        ST_LEN: if (press) begin
          len <= {1'b0, DataIn[0:LW-1]} + (LW+1)'(1);
          wp  <= '0;
        end
        ST_DATA: if (press) begin
          bufm[wp] <= DataIn[0:DATA_W-1];
          wp       <= wp + LW'(1);
          if (last_wr) begin
            ri    <= '0;
            chain <= iv;
          end
        end
        ST_RUN: begin
          res[ri] <= res_val;
          ri      <= ri + LW'(1);
          if (cbc) chain <= enc ? core_out : bufm[ri];
          if (last_run) idx <= '0;
        end
        ST_SHOW: if (press && !restart)
          idx <= last_show ? '0 : idx + LW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdes_block_sequencer.sv
// Directed bench: expected blocks queued at entry, checked on display.
module tb_sdes_block_sequencer;

  localparam logic [0:9] KEY  = 10'b1010000010;
  localparam logic [0:7] PT   = 8'b10010111;
  localparam logic [0:7] CT   = 8'b00111000;
  localparam logic [0:9] NEWM = 10'b0000000001;

  logic       clk = 1'b0;
  logic       rst;
  logic [0:9] din;
  logic       btn;
  logic [0:7] dout;
  logic [2:0] stage;
  logic [1:0] sidx;
  logic       busy, done;

  int         checks = 0;
  int         errors = 0;
  int         busy_cnt = 0;
  logic [7:0] exp_q [$];
  logic [0:7] r0, r1;

  sdes_block_sequencer #(
    .DATA_W(8), .KEY_W(10), .DEPTH(4), .DEBOUNCE_CYC(4)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .DataIn      (din),
    .SelectButton(btn),
    .DataOutBlock(dout),
    .Stage       (stage),
    .ShowIndex   (sidx),
    .Busy        (busy),
    .Done        (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (busy) busy_cnt++;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=%0h expected=<empty queue>", tag, dout);
    end else begin
      e = exp_q.pop_front();
      check(tag, dout, e);
    end
  endtask

  task automatic press(input logic [0:9] d);
    din = d;
    btn = 1'b1;
    repeat (10) @(negedge clk);
    btn = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, done, 1);
  endtask

  initial begin
    rst = 1'b1;
    din = '0;
    btn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_stage", stage, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dout", dout, 0);
    check("rst_sidx", sidx, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single-block ECB encrypt
    press(KEY);
    check("s1_mode_stage", stage, 1);
    press(10'b1000000000);
    check("s1_len_stage", stage, 3);
    press(10'b0000000000);
    check("s1_data_stage", stage, 4);
    busy_cnt = 0;
    exp_q.push_back(CT);
    press({PT, 2'b00});
    wait_done("s1_done");
    check("s1_busy_cycles", busy_cnt, 1);
    pop_check("s1_ecb_enc");
    press(NEWM);

    // 2: ECB decrypt
    press(KEY);
    press(10'b0000000000);
    press(10'b0000000000);
    exp_q.push_back(PT);
    press({CT, 2'b00});
    wait_done("s2_done");
    pop_check("s2_ecb_dec");
    press(NEWM);

    // 3a: CBC encrypt, zero IV, one block equals ECB
    press(KEY);
    press(10'b1100000000);
    check("s3_iv_stage", stage, 2);
    press(10'b0000000000);
    check("s3_len_stage", stage, 3);
    press(10'b0000000000);
    exp_q.push_back(CT);
    press({PT, 2'b00});
    wait_done("s3a_done");
    pop_check("s3a_cbc_enc");
    press(NEWM);

    // 3b: CBC encrypt, two identical blocks
    press(KEY);
    press(10'b1100000000);
    press(10'b0000000000);
    press(10'b0100000000);
    exp_q.push_back(CT);
    press({PT, 2'b00});
    press({PT, 2'b00});
    wait_done("s3b_done");
    r0 = dout;
    pop_check("s3b_res0");
    press(10'b0000000000);
    check("s3b_sidx", sidx, 1);
    r1 = dout;
    checks++;
    assert (r1 !== r0) else begin
      errors++;
      $error("FAIL s3b_chain observed=%0h expected=not %0h", r1, r0);
    end
    press(NEWM);

    // 3c: CBC decrypt restores the plaintext
    press(KEY);
    press(10'b0100000000);
    press(10'b0000000000);
    press(10'b0100000000);
    exp_q.push_back(PT);
    press({r0, 2'b00});
    exp_q.push_back(PT);
    press({r1, 2'b00});
    wait_done("s3c_done");
    pop_check("s3c_dec0");
    press(10'b0000000000);
    pop_check("s3c_dec1");
    press(NEWM);

    // 4: paging with len=3 and restart
    press(KEY);
    press(10'b1000000000);
    press(10'b1000000000);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(CT);
      press({PT, 2'b00});
    end
    wait_done("s4_done");
    check("s4_sidx0", sidx, 0);
    pop_check("s4_blk0");
    pop_check("s4_blk1_pre");
    exp_q.push_front(CT);
    exp_q.push_front(CT);
    press(10'b0000000000);
    check("s4_sidx1", sidx, 1);
    pop_check("s4_blk1");
    press(10'b0000000000);
    check("s4_sidx2", sidx, 2);
    pop_check("s4_blk2");
    exp_q.push_back(CT);
    press(10'b0000000000);
    check("s4_sidx_wrap", sidx, 0);
    pop_check("s4_blk_wrap");
    exp_q.push_back(CT);
    press(10'b0000000000);
    check("s4_sidx_again", sidx, 1);
    pop_check("s4_blk_again");
    press(NEWM);
    check("s4_restart_stage", stage, 0);
    check("s4_restart_done", done, 0);

    // 5: bounce then clean hold gives one advance; short hold none
    din = KEY;
    for (int i = 0; i < 5; i++) begin
      btn = 1'b1;
      repeat (2) @(negedge clk);
      btn = 1'b0;
      repeat (2) @(negedge clk);
    end
    check("s5_bounce_only", stage, 0);
    btn = 1'b1;
    repeat (10) @(negedge clk);
    btn = 1'b0;
    repeat (10) @(negedge clk);
    check("s5_one_advance", stage, 1);
    btn = 1'b1;
    repeat (3) @(negedge clk);
    btn = 1'b0;
    repeat (10) @(negedge clk);
    check("s5_short_hold", stage, 1);

    // 6: reset in the second RUN cycle of a 4-block message
    press(10'b1000000000);
    press(10'b1100000000);
    for (int i = 0; i < 3; i++) press({PT, 2'b00});
    din = {PT, 2'b00};
    btn = 1'b1;
    begin
      int n;
      n = 0;
      while (!busy && n < 60) begin
        @(negedge clk);
        n++;
      end
    end
    check("s6_run_entered", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    btn = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("s6_rst_stage", stage, 0);
    check("s6_rst_busy", busy, 0);
    check("s6_rst_dout", dout, 0);
    repeat (5) @(negedge clk);
    press(KEY);
    press(10'b1000000000);
    press(10'b0000000000);
    busy_cnt = 0;
    exp_q.push_back(CT);
    press({PT, 2'b00});
    wait_done("s6_done");
    check("s6_busy_cycles", busy_cnt, 1);
    pop_check("s6_ecb_again");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
